// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, enable
// encodings, stall-vector bit positions and the decision enums used by
// the PC register and the IF/ID register.
package inst_fetch_pkg;

  // Bus widths shared with the rest of the core
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  // Level encodings
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Constant words
  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0000;

  // Bit positions inside the pipeline stall vector
  localparam int unsigned STALL_PC_BIT = 0;
  localparam int unsigned STALL_IF_BIT = 1;
  localparam int unsigned STALL_ID_BIT = 2;
  localparam int unsigned STALL_W      = 3;

  // Where the next PC comes from, in priority order
  typedef enum logic [2:0] {
    PC_SRC_RESET,
    PC_SRC_FLUSH,
    PC_SRC_HOLD,
    PC_SRC_BRANCH,
    PC_SRC_SEQ
  } pc_src_e;

  // What the IF/ID register does on the coming edge
  typedef enum logic [1:0] {
    IFID_BUBBLE,
    IFID_CAPTURE,
    IFID_HOLD
  } ifid_op_e;

  // Instruction fetches must be word aligned
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if_id.sv
// IF/ID pipeline register and accepted-instruction counter. Bubbles on
// flush or when IF stalls while ID moves on, captures otherwise unless
// both stages are held.
module inst_fetch_if_id
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W,
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic              ce_q,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rom_ce,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel,
  output logic [31:0]       fetch_count
);

  ifid_op_e ifid_op;

  // Decide bubble / capture / hold for the coming edge
  always_comb begin
    ifid_op = IFID_HOLD;
    if (flush) begin
      ifid_op = IFID_BUBBLE;
    end else if (stall_if && !stall_id) begin
      // ID advances while IF cannot supply a new word: insert a bubble
      ifid_op = IFID_BUBBLE;
    end else if (!stall_if) begin
      ifid_op = IFID_CAPTURE;
    end
  end

  // Pipeline register and counter update
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      id_pc       <= '0;
      id_inst     <= DATA_W'(ZERO_WORD);
      id_valid    <= 1'b0;
      id_adel     <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (ifid_op)
        IFID_BUBBLE: begin
          id_pc    <= '0;
          id_inst  <= DATA_W'(NOP_INST);
          id_valid <= 1'b0;
          id_adel  <= 1'b0;
        end
        IFID_CAPTURE: begin
          id_pc    <= pc;
          // A misaligned PC never enables the ROM; pass a NOP instead
          id_inst  <= rom_ce ? rom_data : DATA_W'(NOP_INST);
          id_valid <= ce_q;
          id_adel  <= ce_q && !is_aligned(pc[1:0]);
          if (ce_q) begin
            fetch_count <= fetch_count + 32'd1;
          end
        end
        default: begin
          // hold: all IF/ID state keeps its value
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_pc_reg.sv
// Program counter and chip-enable register. Chooses the next PC from
// reset, exception flush, stall, taken branch or sequential increment.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              ce_q,
  output logic [ADDR_W-1:0] pc
);

  pc_src_e           pc_src;
  logic [ADDR_W-1:0] pc_next;

  // Select the next-PC source; earlier branches win
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    pc_src = PC_SRC_SEQ;
    if (ce_q == CHIP_DISABLE) begin
      pc_src = PC_SRC_RESET;
    end else if (flush) begin
      pc_src = PC_SRC_FLUSH;
    end else if (stall_pc) begin
      // A branch seen during a stall is dropped; ID keeps asserting it
      // until the stall releases.
      pc_src = PC_SRC_HOLD;
    end else if (branch_flag_i) begin
      pc_src = PC_SRC_BRANCH;
    end
  end

  // Form the next PC value for the chosen source
  always_comb begin
    pc_next = pc + ADDR_W'(4);
    unique case (pc_src)
      PC_SRC_RESET:  pc_next = RESET_PC;
      PC_SRC_FLUSH:  pc_next = new_pc;
      PC_SRC_HOLD:   pc_next = pc;
      PC_SRC_BRANCH: pc_next = branch_target_address_i;
      PC_SRC_SEQ:    pc_next = pc + ADDR_W'(4);
      default:       pc_next = pc + ADDR_W'(4);
    endcase
  end

  // PC and chip-enable state; ce rises on the first edge out of reset
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst == RST_ENABLE) begin
      ce_q <= CHIP_DISABLE;
      pc   <= RESET_PC;
    end else begin
      ce_q <= CHIP_ENABLE;
      pc   <= pc_next;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage top: PC register plus IF/ID register, with the
// ROM chip enable and byte address derived from the current PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic              id_adel_o,
  output logic [31:0]       fetch_count_o
);

  logic [STALL_W-1:0] stall;
  logic               ce_q;
  logic [ADDR_W-1:0]  pc;

  // Gather the individual stall bits into the core's stall-vector layout
  always_comb begin
    stall               = '0;
    stall[STALL_PC_BIT] = stall_pc;
    stall[STALL_IF_BIT] = stall_if;
    stall[STALL_ID_BIT] = stall_id;
  end

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk                     (clk),
    .rst                     (rst),
    .stall_pc                (stall[STALL_PC_BIT]),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ce_q                    (ce_q),
    .pc                      (pc)
  );

  // ROM is addressed by the PC and only enabled for aligned fetches
  always_comb begin
    rom_addr_o = pc;
    rom_ce_o   = ce_q && is_aligned(pc[1:0]);
  end

  inst_fetch_if_id #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .stall_if    (stall[STALL_IF_BIT]),
    .stall_id    (stall[STALL_ID_BIT]),
    .flush       (flush),
    .ce_q        (ce_q),
    .pc          (pc),
    .rom_ce      (rom_ce_o),
    .rom_data    (rom_data_i),
    .id_pc       (id_pc_o),
    .id_inst     (id_inst_o),
    .id_valid    (id_valid_o),
    .id_adel     (id_adel_o),
    .fetch_count (fetch_count_o)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. The ROM model returns 0xA500_0000 ^ (addr>>2),
// so word i sits at byte address 4i and all expected words are hand-derived.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pc, stall_if, stall_id, flush, branch_flag_i;
  logic [31:0] new_pc, branch_target_address_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o, rom_data_i;
  logic [31:0] id_pc_o, id_inst_o, fetch_count_o;
  logic        id_valid_o, id_adel_o;

  int tests_run = 0;
  int tests_failed = 0;

  inst_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_pc                (stall_pc),
    .stall_if                (stall_if),
    .stall_id                (stall_id),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom_ce_o                (rom_ce_o),
    .rom_addr_o              (rom_addr_o),
    .rom_data_i              (rom_data_i),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .id_valid_o              (id_valid_o),
    .id_adel_o               (id_adel_o),
    .fetch_count_o           (fetch_count_o)
  );

  always #5 clk = ~clk;

  // Combinational instruction ROM
  always_comb rom_data_i = 32'hA500_0000 ^ (rom_addr_o >> 2);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic valid, input logic adel, input logic [31:0] cnt);
    check({tag, ".id_pc"}, id_pc_o, pc);
    check({tag, ".id_inst"}, id_inst_o, inst);
    check({tag, ".id_valid"}, {31'd0, id_valid_o}, {31'd0, valid});
    check({tag, ".id_adel"}, {31'd0, id_adel_o}, {31'd0, adel});
    check({tag, ".count"}, fetch_count_o, cnt);
  endtask

  task automatic check_rom(input string tag, input logic [31:0] addr, input logic ce);
    check({tag, ".rom_addr"}, rom_addr_o, addr);
    check({tag, ".rom_ce"}, {31'd0, rom_ce_o}, {31'd0, ce});
  endtask

  initial begin
    rst = 1'b1; stall_pc = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    flush = 1'b0; branch_flag_i = 1'b0; new_pc = '0; branch_target_address_i = '0;

    // ---- 1: reset, then free-running fetch ----
    tick(); tick();
    check_rom("rst", 32'h0, 1'b0);
    check_if("rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    tick();  // ce rises, pc forced to RESET_PC, nothing valid yet
    check_rom("seq0", 32'h0, 1'b1);
    check_if("seq0", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    check_rom("seq1", 32'h4, 1'b1);
    check_if("seq1", 32'h0, 32'hA500_0000, 1'b1, 1'b0, 32'd1);
    tick();
    check_rom("seq2", 32'h8, 1'b1);
    check_if("seq2", 32'h4, 32'hA500_0001, 1'b1, 1'b0, 32'd2);
    tick();
    check_rom("seq3", 32'hC, 1'b1);
    check_if("seq3", 32'h8, 32'hA500_0002, 1'b1, 1'b0, 32'd3);

    // ---- 2: branch resolved with 0x8 in ID; 0xC is the delay slot ----
    branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
    tick();
    branch_flag_i = 1'b0;
    check_rom("br0", 32'h40, 1'b1);
    check_if("br0", 32'hC, 32'hA500_0003, 1'b1, 1'b0, 32'd4);
    tick();
    check_rom("br1", 32'h44, 1'b1);
    check_if("br1", 32'h40, 32'hA500_0010, 1'b1, 1'b0, 32'd5);

    // move to pc=0x10 for the stall test
    branch_flag_i = 1'b1; branch_target_address_i = 32'h10;
    tick();
    branch_flag_i = 1'b0;
    check_rom("br2", 32'h10, 1'b1);
    check_if("br2", 32'h44, 32'hA500_0011, 1'b1, 1'b0, 32'd6);

    // ---- 3: full stall for 3 cycles, then IF stalls while ID moves ----
    stall_pc = 1'b1; stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rom("stall", 32'h10, 1'b1);
      check_if("stall", 32'h44, 32'hA500_0011, 1'b1, 1'b0, 32'd6);
    end
    stall_id = 1'b0;
    tick();
    check_rom("bubble", 32'h10, 1'b1);
    check_if("bubble", 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
    stall_pc = 1'b0; stall_if = 1'b0;
    tick();
    check_rom("unstall", 32'h14, 1'b1);
    check_if("unstall", 32'h10, 32'hA500_0004, 1'b1, 1'b0, 32'd7);

    // ---- 4: flush beats concurrent stall and branch ----
    flush = 1'b1; new_pc = 32'h180; stall_pc = 1'b1;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
    tick();
    flush = 1'b0; stall_pc = 1'b0; branch_flag_i = 1'b0;
    check_rom("flush", 32'h180, 1'b1);
    check_if("flush", 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
    tick();
    check_rom("flush1", 32'h184, 1'b1);
    check_if("flush1", 32'h180, 32'hA500_0060, 1'b1, 1'b0, 32'd8);

    // ---- 5: misaligned branch target 0x42 ----
    branch_flag_i = 1'b1; branch_target_address_i = 32'h42;
    tick();
    branch_flag_i = 1'b0;
    check_rom("mis0", 32'h42, 1'b0);
    check_if("mis0", 32'h184, 32'hA500_0061, 1'b1, 1'b0, 32'd9);
    tick();
    check_rom("mis1", 32'h46, 1'b0);
    check_if("mis1", 32'h42, 32'h0, 1'b1, 1'b1, 32'd10);

    // ---- 6: reset mid-stream at pc=0x20, with stall and flush asserted ----
    branch_flag_i = 1'b1; branch_target_address_i = 32'h20;
    tick();
    branch_flag_i = 1'b0;
    check_rom("pre_rst", 32'h20, 1'b1);
    check_if("pre_rst", 32'h46, 32'h0, 1'b1, 1'b1, 32'd11);
    rst = 1'b1; stall_pc = 1'b1; stall_if = 1'b1; stall_id = 1'b1;
    flush = 1'b1; new_pc = 32'h300;
    tick();
    check_rom("rst2", 32'h0, 1'b0);
    check_if("rst2", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0; stall_pc = 1'b0; stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0;
    tick();
    check_rom("restart0", 32'h0, 1'b1);
    check_if("restart0", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    check_rom("restart1", 32'h4, 1'b1);
    check_if("restart1", 32'h0, 32'hA500_0000, 1'b1, 1'b0, 32'd1);

    // ---- PC wraps modulo 2^32 ----
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 1'b0;
    check_rom("wrap0", 32'hFFFF_FFFC, 1'b1);
    tick();
    check_rom("wrap1", 32'h0, 1'b1);
    check_if("wrap1", 32'hFFFF_FFFC, 32'h9AFF_FFFF, 1'b1, 1'b0, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
